// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared state encoding, source count and round-robin pick helper
package mux_rr_arbiter_pkg;
    localparam int NUM_SRC = 4;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    // First set request at or after ptr, wrapping; descending scan lets the nearest offset win.
    function automatic logic [1:0] rr_pick(input logic [NUM_SRC-1:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction
endpackage

// File: rtl/mux_rr_arbiter_mux.sv
// mux_4x1_32b: 32-bit 4:1 data mux steered by {s1,s0}
module mux_4x1_32b (
    input  logic        s1,
    input  logic        s0,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] C,
    input  logic [31:0] D,
    output logic [31:0] Y
);
    assign Y = s1 ? (s0 ? D : C) : (s0 ? B : A);
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one 32-bit valid/ready channel among four sources
module mux_rr_arbiter
    import mux_rr_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [31:0]        A,
    input  logic [31:0]        B,
    input  logic [31:0]        C,
    input  logic [31:0]        D,
    output logic [31:0]        Y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_SRC-1:0] ack,
    output logic               s1,
    output logic               s0,
    output logic               busy
);
    logic [0:0]       state;
    logic [1:0]       sel;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] beat_cnt;
    logic             transfer;
    logic             last_beat;
    logic             release_grant;

    assign {s1, s0}      = sel;
    assign busy          = state == BUSY;
    assign out_valid     = busy & req[sel];
    assign transfer      = out_valid & out_ready;
    assign ack           = {3'b000, transfer} << sel;
    assign last_beat     = transfer & (beat_cnt == CNT_W'(MAX_BURST - 1));
    // A dropped request ends the grant even mid-burst; no ack is issued for it.
    assign release_grant = busy & (~req[sel] | last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 2'd0;
            ptr      <= 2'd0;
            beat_cnt <= '0;
        end else if (state == IDLE) begin
            if (|req) begin
                sel      <= rr_pick(req, ptr);
                beat_cnt <= '0;
                state    <= BUSY;
            end
        end else if (release_grant) begin
            ptr   <= sel + 2'd1;
            state <= IDLE;
        end else if (transfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    mux_4x1_32b u_mux (
        .s1(s1),
        .s0(s0),
        .A (A),
        .B (B),
        .C (C),
        .D (D),
        .Y (Y)
    );
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios plus randomized traffic checked against a behavioural model
module tb_mux_rr_arbiter;
    localparam int MB = 4;
    logic        clk = 0, rst_n = 1, out_ready = 0;
    logic [3:0]  req = 0;
    logic [31:0] a = 0, b = 0, c = 0, d = 0;
    logic [31:0] y;
    logic [3:0]  ack;
    logic        out_valid, s1, s0, busy;
    int tests = 0, fails = 0;
    int m_owner = -1, m_sel = 0, m_ptr = 0, m_beats = 0;
    bit m_x, cmp_en = 0;

    mux_rr_arbiter #(.MAX_BURST(MB), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .A(a), .B(b), .C(c), .D(d), .Y(y),
        .out_valid(out_valid), .out_ready(out_ready), .ack(ack), .s1(s1), .s0(s0), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dat(input int i);
        return i == 0 ? a : i == 1 ? b : i == 2 ? c : d;
    endfunction

    // Behavioural model: owner index or -1, rotating priority pointer, beats served this grant.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = -1; m_sel = 0; m_ptr = 0; m_beats = 0;
        end else if (m_owner < 0) begin
            if (req != 0) begin
                for (int k = 0; k < 4; k++)
                    if (req[(m_ptr + k) % 4]) begin m_owner = (m_ptr + k) % 4; break; end
                m_sel = m_owner; m_beats = 0;
            end
        end else begin
            m_x = req[m_owner] && out_ready;
            if (m_x) m_beats++;
            if (!req[m_owner] || m_beats == MB) begin
                m_ptr = (m_owner + 1) % 4; m_owner = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic ev;
            ev = (m_owner >= 0) ? req[m_owner] : 1'b0;
            check("busy", busy, m_owner >= 0);
            check("sel", {s1, s0}, m_sel);
            check("valid", out_valid, ev);
            check("ack", ack, (ev && out_ready) ? (32'd1 << m_owner) : 32'd0);
            check("y", y, dat(m_sel));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        rst_n = 0; req = 0; out_ready = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        int na, gword, ng, okc;
        int acks[4];
        logic pb;
        cmp_en = 1;
        a = 32'hAAAA0000; b = 32'hBBBB1111; c = 32'hCCCC2222; d = 32'hDDDD3333;
        #1 rst_n = 0; req = 4'b1111; out_ready = 1;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ack", ack, 0);
        check("rst_sel", {s1, s0}, 0);
        check("rst_y", y, 32'hAAAA0000);
        step();
        rst_n = 1;
        gword = 0; ng = 0; pb = 0; acks = '{0, 0, 0, 0};
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (busy && !pb) begin gword = (gword << 2) | {s1, s0}; ng++; end
            pb = busy;
            for (int j = 0; j < 4; j++) acks[j] += ack[j];
        end
        check("rr_grants", ng, 5);
        check("rr_order", gword, 32'h6C);
        check("rr_acks_a", acks[0], 8);
        check("rr_acks_b", acks[1], 4);
        check("rr_acks_c", acks[2], 4);
        check("rr_acks_d", acks[3], 4);

        reset_dut();
        req = 4'b0010; out_ready = 1; na = 0;
        step();
        repeat (2) begin @(negedge clk); na += ack[1]; step(); end
        req = 4'b1001;
        @(negedge clk);
        check("short_noack", ack, 0);
        step(); step();
        @(negedge clk);
        check("short_acks", na, 2);
        check("short_next_d", {busy, s1, s0}, 3'b111);

        reset_dut();
        c = 32'h12345678; d = 32'hDEADBEEF; req = 4'b1100; out_ready = 0; okc = 0;
        step();
        repeat (10) begin
            @(negedge clk);
            if (out_valid && busy && y == 32'h12345678 && ack == 0 && {s1, s0} == 2'd2) okc++;
            step();
        end
        check("bp_hold", okc, 10);
        out_ready = 1;
        @(negedge clk);
        check("bp_ack", ack, 4'b0100);

        reset_dut();
        req = 4'b0010; out_ready = 1;
        step();
        req = 4'b0000;
        step();
        req = 4'b0001;
        repeat (3) step();
        check("mid_pre_ack", ack, 4'b0001);
        rst_n = 0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_valid", out_valid, 0);
        check("mid_ack", ack, 0);
        check("mid_sel", {s1, s0}, 0);
        step();
        rst_n = 1; req = 4'b1001;
        step();
        @(negedge clk);
        check("mid_regrant_a", {busy, s1, s0}, 3'b100);

        reset_dut();
        req = 4'b1000; out_ready = 0;
        step();
        @(negedge clk);
        check("abort_grant_d", {busy, s1, s0}, 3'b111);
        step();
        req = 4'b0001; out_ready = 1;
        @(negedge clk);
        check("abort_noack", {out_valid, ack}, 0);
        step(); step();
        @(negedge clk);
        check("abort_next_a", {busy, s1, s0}, 3'b100);

        reset_dut();
        repeat (3000) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (req[i]) req[i] = $urandom_range(0, 7) != 0;
                else begin
                    req[i] = $urandom_range(0, 3) == 0;
                    case (i)
                        0: a = $urandom;
                        1: b = $urandom;
                        2: c = $urandom;
                        default: d = $urandom;
                    endcase
                end
            end
            out_ready = $urandom_range(0, 3) != 0;
            rst_n = $urandom_range(0, 199) != 0;
        end
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
